// File: rtl/dh_key_sequencer.sv
// rtl/dh_key_sequencer.sv - Diffie-Hellman private-exponent and key sequencer driving a modular powering unit.
// Optional powering-unit watchdog: define DH_SEQ_WDOG_EN.
module dh_key_sequencer #(
   parameter int             N        = 8,
   parameter int             P        = 7,
   parameter int             G        = 3,
   parameter logic [N-1:0]   SEED     = 'hA5,
   parameter int             WDOG_CYC = 2 * (2 ** N) + 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         start,
   input  logic         priv_ext_en,
   input  logic [N-1:0] priv_ext,
   input  logic [N-1:0] peer_key,
   input  logic         peer_valid,
   output logic         pw_start,
   output logic [N-1:0] pw_base,
   output logic [N-1:0] pw_exp,
   input  logic [N-1:0] pw_res,
   input  logic         pw_rdy,
   output logic [N-1:0] pub_key,
   output logic         pub_valid,
   output logic [N-1:0] secret,
   output logic         secret_valid,
   output logic         busy,
   output logic         err,
   output logic [1:0]   err_code
);

   typedef enum logic [3:0] {
      S_IDLE, S_CHK_PRIV, S_PUB_REQ, S_PUB_WAIT, S_PEER_WAIT,
      S_SEC_REQ, S_SEC_WAIT, S_DONE, S_ERR
   } state_t;

   // Right-shifting Galois feedback masks for maximal-length polynomials.
   function automatic logic [31:0] galois_taps(input int width);
      case (width)
         3:       return 32'h0006;
         4:       return 32'h000C;
         5:       return 32'h0014;
         6:       return 32'h0030;
         7:       return 32'h0060;
         9:       return 32'h0110;
         10:      return 32'h0240;
         11:      return 32'h0500;
         12:      return 32'h0E08;
         13:      return 32'h1C80;
         14:      return 32'h3802;
         15:      return 32'h6000;
         16:      return 32'hD008;
         default: return 32'h00B8;
      endcase
   endfunction

   localparam logic [31:0]  TAPS32 = galois_taps(N);
   localparam logic [N-1:0] TAPS   = TAPS32[N-1:0];
   localparam logic [N-1:0] P_M2   = N'(P - 2);
   localparam logic [N-1:0] P_M1   = N'(P - 1);
   localparam logic [N-1:0] G_W    = N'(G);
   localparam logic [N-1:0] TWO    = N'(2);

   state_t       state, state_n;
   logic [1:0]   code_n;
   logic [N-1:0] lfsr, lfsr_next, priv, priv_lfsr;
   logic         wdog_hit, enter_err, start_ok;

   assign lfsr_next = {1'b0, lfsr[N-1:1]} ^ (lfsr[0] ? TAPS : '0);
   assign priv_lfsr = (lfsr % P_M2) + N'(1);

`ifdef DH_SEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog_cnt;

   // Restarts from zero every time a wait state is entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wdog_cnt <= '0;
      else if (ena) begin
         if (state == S_PUB_WAIT || state == S_SEC_WAIT)
            wdog_cnt <= wdog_cnt + WW'(1);
         else
            wdog_cnt <= '0;
      end
   end

   assign wdog_hit = (wdog_cnt == WW'(WDOG_CYC - 1));
`else
   assign wdog_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else if (ena)
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      code_n  = 2'b00;
      case (state)
         S_IDLE, S_DONE, S_ERR:
            if (start) state_n = S_CHK_PRIV;
         S_CHK_PRIV:
            if (priv == '0 || priv > P_M2) begin
               state_n = S_ERR;
               code_n  = 2'b01;
            end else
               state_n = S_PUB_REQ;
         S_PUB_REQ:
            state_n = S_PUB_WAIT;
         S_PUB_WAIT:
            if (pw_rdy)
               state_n = S_PEER_WAIT;
            else if (wdog_hit) begin
               state_n = S_ERR;
               code_n  = 2'b11;
            end
         S_PEER_WAIT:
            if (peer_valid) begin
               if (peer_key < TWO || peer_key >= P_M1) begin
                  state_n = S_ERR;
                  code_n  = 2'b10;
               end else
                  state_n = S_SEC_REQ;
            end
         S_SEC_REQ:
            state_n = S_SEC_WAIT;
         S_SEC_WAIT:
            if (pw_rdy)
               state_n = S_DONE;
            else if (wdog_hit) begin
               state_n = S_ERR;
               code_n  = 2'b11;
            end
         default:
            state_n = S_IDLE;
      endcase
   end

   assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
   assign enter_err = (state_n == S_ERR) && (state != S_ERR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr         <= SEED;
         priv         <= '0;
         pw_base      <= '0;
         pw_exp       <= '0;
         pub_key      <= '0;
         pub_valid    <= 1'b0;
         secret       <= '0;
         secret_valid <= 1'b0;
         err          <= 1'b0;
         err_code     <= 2'b00;
      end else if (ena) begin
         lfsr <= lfsr_next;
         if (start_ok) begin
            priv         <= priv_ext_en ? priv_ext : priv_lfsr;
            pub_valid    <= 1'b0;
            secret_valid <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'b00;
         end
         // Operands stay put through the wait; the unit samples them late.
         if (state == S_CHK_PRIV && state_n == S_PUB_REQ) begin
            pw_base <= G_W;
            pw_exp  <= priv;
         end
         if (state == S_PEER_WAIT && state_n == S_SEC_REQ) begin
            pw_base <= peer_key;
            pw_exp  <= priv;
         end
         if (state == S_PUB_WAIT && pw_rdy) begin
            pub_key   <= pw_res;
            pub_valid <= 1'b1;
         end
         if (state == S_SEC_WAIT && pw_rdy) begin
            secret       <= pw_res;
            secret_valid <= 1'b1;
         end
         if (enter_err) begin
            err          <= 1'b1;
            err_code     <= code_n;
            secret       <= '0;
            secret_valid <= 1'b0;
            if (code_n != 2'b10) begin
               pub_key   <= '0;
               pub_valid <= 1'b0;
            end
         end
      end
   end

   assign pw_start = ena && (state == S_PUB_REQ || state == S_SEC_REQ);
   assign busy     = !(state == S_IDLE || state == S_DONE || state == S_ERR);

endmodule

// File: tb/tb_dh_key_sequencer.sv
// tb/tb_dh_key_sequencer.sv - self-checking bench for dh_key_sequencer with a behavioural powering unit.
module tb_dh_key_sequencer;

   localparam int MODP     = 7;
   localparam int GEN      = 3;
   localparam int WDOG_CYC = 2 * 256 + 8;

   logic       clk = 1'b0;
   logic       rst, ena, start, priv_ext_en, peer_valid, pw_rdy;
   logic [7:0] priv_ext, peer_key, pw_res;
   logic       pw_start, pub_valid, secret_valid, busy, err;
   logic [7:0] pw_base, pw_exp, pub_key, secret;
   logic [1:0] err_code;

   int         tests = 0;
   int         fails = 0;

   logic [7:0] cap_base, cap_exp, cap_res;
   int         pu_cnt = 0;
   bit         pu_arm = 0;
   bit         pu_stall = 0;
   int         pu_starts = 0;
   int         stable_bad = 0;

   dh_key_sequencer dut (
      .clk(clk), .rst(rst), .ena(ena), .start(start),
      .priv_ext_en(priv_ext_en), .priv_ext(priv_ext),
      .peer_key(peer_key), .peer_valid(peer_valid),
      .pw_start(pw_start), .pw_base(pw_base), .pw_exp(pw_exp),
      .pw_res(pw_res), .pw_rdy(pw_rdy),
      .pub_key(pub_key), .pub_valid(pub_valid),
      .secret(secret), .secret_valid(secret_valid),
      .busy(busy), .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   function automatic int modpow(input int b, input int e, input int m);
      int r = 1;
      for (int k = 0; k < e; k++) r = (r * b) % m;
      return r;
   endfunction

   // Powering unit: operands sampled one cycle after start, result after 2*exp+2 cycles.
   always @(negedge clk) begin
      if (rst) begin
         pw_rdy = 1'b0;
         pu_arm = 0;
         pu_cnt = 0;
      end else begin
         pw_rdy = 1'b0;
         if (pu_cnt > 0) begin
            if (pw_exp !== cap_exp || pw_base !== cap_base) stable_bad++;
            pu_cnt--;
            if (pu_cnt == 0 && !pu_stall) begin
               pw_rdy = 1'b1;
               pw_res = cap_res;
            end
         end
         if (pw_start) begin
            pu_arm = 1;
            pu_starts++;
         end else if (pu_arm) begin
            pu_arm   = 0;
            cap_base = pw_base;
            cap_exp  = pw_exp;
            cap_res  = 8'(modpow(int'(pw_base), int'(pw_exp), MODP));
            pu_cnt   = 2 * int'(pw_exp) + 2;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic wait_flags(input bit want_idle);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (want_idle ? !busy : (pub_valid || err)) return;
      end
      chk("wait_timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_start(input logic ext_en, input logic [7:0] ext);
      priv_ext_en = ext_en;
      priv_ext    = ext;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_peer(input logic [7:0] pk);
      peer_key   = pk;
      peer_valid = 1'b1;
      @(negedge clk);
      peer_valid = 1'b0;
   endtask

   task automatic exchange(input logic ext_en, input logic [7:0] ext, input logic [7:0] pk);
      pulse_start(ext_en, ext);
      wait_flags(0);
      if (pub_valid) begin
         send_peer(pk);
         wait_flags(1);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_keys"}, {pub_key, secret, pw_base, pw_exp}, 32'd0);
      chk({tag, "_flags"}, {26'd0, pub_valid, secret_valid, err, err_code, busy, pw_start}, 32'd0);
   endtask

   initial begin
      int pe, pk, e, n0, cyc;
      rst = 1'b1; ena = 1'b1; start = 1'b0; priv_ext_en = 1'b0; priv_ext = '0;
      peer_key = '0; peer_valid = 1'b0; pw_res = '0; pw_rdy = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      exchange(1'b1, 8'd2, 8'd4);
      chk("t1_pub", pub_key, 32'd2);
      chk("t1_secret", secret, 32'd2);
      chk("t1_valid", {pub_valid, secret_valid, err}, 32'b110);

      exchange(1'b1, 8'd5, 8'd3);
      chk("t2_pub", pub_key, 32'd5);
      chk("t2_secret", secret, 32'd5);
      chk("t2_exp_stable", stable_bad, 32'd0);

      n0 = pu_starts;
      pulse_start(1'b1, 8'd0);
      @(negedge clk);
      chk("t3_err", {err, err_code}, 32'b101);
      chk("t3_no_pw_start", pu_starts - n0, 32'd0);
      chk("t3_pub_cleared", {pub_valid, secret_valid, secret}, 32'd0);

      exchange(1'b1, 8'd3, 8'd6);
      chk("t4_pub", {pub_valid, pub_key}, {23'd0, 1'b1, 8'd6});
      chk("t4_err", {err, err_code}, 32'b110);
      chk("t4_secret", {secret_valid, secret}, 32'd0);

      ena = 1'b0;
      pulse_start(1'b1, 8'd2);
      repeat (3) @(negedge clk);
      chk("ena_hold_busy", busy, 32'd0);
      ena = 1'b1;
      @(negedge clk);

      for (int it = 0; it < 12; it++) begin
         pe = $urandom_range(0, 7);
         pk = $urandom_range(0, 7);
         exchange(1'b1, 8'(pe), 8'(pk));
         if (pe < 1 || pe > MODP - 2) begin
            chk("rnd_bad_priv", {err, err_code, pub_valid, secret_valid}, 32'b10100);
         end else begin
            chk("rnd_pub", pub_key, modpow(GEN, pe, MODP));
            if (pk < 2 || pk >= MODP - 1)
               chk("rnd_bad_peer", {err, err_code, pub_valid, secret_valid, secret}, {21'd0, 3'b110, 1'b1, 1'b0, 8'd0});
            else
               chk("rnd_secret", {err, secret_valid, secret}, {22'd0, 2'b01, 8'(modpow(pk, pe, MODP))});
         end
      end

      for (int it = 0; it < 10; it++) begin
         pk = $urandom_range(2, MODP - 2);
         exchange(1'b0, 8'd0, 8'(pk));
         e = int'(cap_exp);
         chk("lfsr_exp_range", (e >= 1 && e <= MODP - 2), 32'd1);
         chk("lfsr_pub", pub_key, modpow(GEN, e, MODP));
         chk("lfsr_secret", {secret_valid, secret}, {23'd0, 1'b1, 8'(modpow(pk, e, MODP))});
      end
      chk("lfsr_exp_stable", stable_bad, 32'd0);

      pulse_start(1'b1, 8'd5);
      wait_flags(0);
      send_peer(8'd3);
      repeat (4) @(negedge clk);
      chk("mid_busy", busy, 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exchange(1'b1, 8'd2, 8'd4);
      chk("post_reset_secret", {secret_valid, secret}, {23'd0, 1'b1, 8'd2});

`ifdef DH_SEQ_WDOG_EN
      pu_stall = 1;
      pulse_start(1'b1, 8'd2);
      cyc = 0;
      while (!err && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("wdog_code", {err, err_code}, 32'b111);
      chk("wdog_not_early", (cyc >= WDOG_CYC), 32'd1);
      chk("wdog_pub_cleared", {pub_valid, pw_start}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pu_stall = 0;
`else
      cyc = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dh_key_sequencer.md
Name: dh_key_sequencer

Overview:
- Control stage directly upstream of the modular powering unit in the Diffie-Hellman key-exchange datapath.
- Picks a private exponent, either from an internal LFSR or from an external load, and drives the powering unit to compute the public key G^priv mod P.
- Accepts the peer's public key, validates it, then drives the powering unit again to compute the shared secret peer^priv mod P.
- Owns the powering unit's start/base/exp inputs and consumes its res/rdy outputs.

Parameters:
- P, 7, prime modulus; must be >= 5 and < 2^N.
- N, 8, width of keys, exponents and all datapath words.
- G, 3, generator; 2 <= G <= P-2.
- SEED, 8'hA5, LFSR reset value; nonzero.
- WDOG_CYC, 2*2^N+8, powering-unit timeout in cycles (WDOG_EN only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  clock enable; when low, all state, counters and the LFSR hold.
- start  in  1  one-cycle pulse; begins an exchange.
- priv_ext_en  in  1  sampled with start: 1 = use priv_ext, 0 = use LFSR.
- priv_ext  in  N  external private exponent.
- peer_key  in  N  peer public key.
- peer_valid  in  1  one-cycle pulse qualifying peer_key.
- pw_start  out  1  start pulse to the powering unit.
- pw_base  out  N  base to the powering unit.
- pw_exp  out  N  exponent to the powering unit.
- pw_res  in  N  powering unit result.
- pw_rdy  in  1  powering unit done pulse; pw_res is valid in the same cycle.
- pub_key  out  N  own public key.
- pub_valid  out  1  level; pub_key is valid.
- secret  out  N  shared secret.
- secret_valid  out  1  level; secret is valid.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- err  out  1  level; exchange aborted.
- err_code  out  2  01 = bad private key, 10 = bad peer key, 11 = timeout.

Behaviour:
- Reset: all outputs 0, state IDLE, LFSR = SEED. Reset mid-operation aborts immediately. The sequencer and the powering unit share clk/rst, so both return to idle together.
- All registers update only when ena = 1.
- LFSR: N-bit Galois, maximal-length taps for N, advances every enabled cycle in every state.
- State IDLE/DONE/ERR, start = 1:
  - clear pub_valid, secret_valid, err and err_code;
  - priv := priv_ext if priv_ext_en = 1, otherwise (LFSR % (P-2)) + 1;
  - go to CHK_PRIV.
  - start in any other state is ignored.
- CHK_PRIV: if priv is 0 or > P-2, go to ERR with code 01. Otherwise drive pw_base = G, pw_exp = priv, go to PUB_REQ.
- PUB_REQ: pw_start = 1 for exactly one cycle, then PUB_WAIT.
- pw_base and pw_exp are held stable from PUB_REQ until pw_rdy, because the powering unit samples them one cycle after start.
- PUB_WAIT: on pw_rdy, pub_key := pw_res, pub_valid := 1, go to PEER_WAIT.
- PEER_WAIT:
  - on peer_valid, validate peer_key: reject if < 2 or >= P-1;
  - reject -> ERR with code 10;
  - accept -> pw_base = peer_key, pw_exp = priv, go to SEC_REQ.
  - peer_valid in any other state is ignored and not buffered.
- SEC_REQ: one-cycle pw_start, then SEC_WAIT.
- SEC_WAIT: on pw_rdy, secret := pw_res, secret_valid := 1, go to DONE.
- DONE: holds pub_key and secret until the next start.
- ERR: holds err = 1 and err_code until the next start. On entry to ERR:
  - secret is forced to 0;
  - pub_key is retained (still valid) only for error code 10.
- pw_rdy outside PUB_WAIT/SEC_WAIT is ignored.
- Simultaneous peer_valid and the pw_rdy that completes PUB_WAIT: peer_valid is dropped, because the block is not yet in PEER_WAIT.
- Latency: CHK_PRIV to pub_valid = 2 + powering-unit latency (2*priv+2 cycles).

Optional Feature:
- Macro: DH_SEQ_WDOG_EN.
- When defined:
  - a cycle counter clears on entry to PUB_WAIT or SEC_WAIT and counts enabled cycles while waiting;
  - reaching WDOG_CYC -> ERR with code 11, pw_start stays 0;
  - the powering unit must be reset externally to recover.
- When undefined: no counter is built, the sequencer waits indefinitely, and err_code 11 never occurs.

Test Plan:
- P=7, G=3, priv_ext_en=1, priv_ext=2, start; then peer_key=4 with peer_valid -> pub_key=2 (9 mod 7), secret=2 (16 mod 7), secret_valid=1, err=0.
- priv_ext=5, peer_key=3 -> pub_key=5 (3^5=243 mod 7), secret=5 (3^5 mod 7), with pw_exp=5 held stable through each wait.
- priv_ext=0, start -> err=1, err_code=01 within 2 cycles, pw_start never pulses.
- priv_ext=3, peer_key=6 -> pub_key=6, pub_valid=1, then err_code=10, secret=0, secret_valid=0.
- LFSR mode, P=7: ten back-to-back exchanges -> every pw_exp lies in 1..5 and secret equals peer_key^pw_exp mod 7 for each.
- Reset pulsed mid SEC_WAIT -> all outputs 0 next cycle. With DH_SEQ_WDOG_EN, a stubbed pw_rdy held low -> err_code=11 after WDOG_CYC cycles.
